// File: rtl/mux_2to1_stream_arb.sv
// Merges two valid/ready byte streams into one registered output stream tagged with its source.
// Define RR_ARB_EN for round-robin arbitration; the default build uses fixed priority (i0 wins).
module mux_2to1_stream_arb #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] i0,
    input  logic             i0_valid,
    output logic             i0_ready,
    input  logic [width-1:0] i1,
    input  logic             i1_valid,
    output logic             i1_ready,
    output logic [width-1:0] o,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_sel
);

    typedef enum logic {
        EMPTY,
        FULL
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_sel;
    logic   can_load;
    logic   grant0;
    logic   grant1;
    logic   load;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (i0_valid && i1_valid) begin
`ifdef RR_ARB_EN
            grant0 = last_sel;
            grant1 = !last_sel;
`else
            grant0 = 1'b1;
`endif
        end else begin
            grant0 = i0_valid;
            grant1 = i1_valid;
        end
    end

`ifndef RR_ARB_EN
    // Under fixed priority the last grant is tracked but never steers the arbiter.
    logic unused_last_sel;
    assign unused_last_sel = last_sel;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Readies are gated by rst_n so no source is accepted while reset is held.
    always_comb begin
        state_next = state;
        can_load   = (state == EMPTY) || o_ready;
        i0_ready   = rst_n && can_load && grant0;
        i1_ready   = rst_n && can_load && grant1;
        load       = i0_ready || i1_ready;
        case (state)
            EMPTY: if (load) state_next = FULL;
            FULL:  if (o_ready && !load) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    assign o_valid = (state == FULL);

    // last_sel resets to 1 so that the first contention goes to i0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o        <= '0;
            o_sel    <= 1'b0;
            last_sel <= 1'b1;
        end else if (load) begin
            o        <= grant1 ? i1 : i0;
            o_sel    <= grant1;
            last_sel <= grant1;
        end
    end

endmodule

// File: tb/tb_mux_2to1_stream_arb.sv
// Directed self-checking bench for mux_2to1_stream_arb; expectations follow RR_ARB_EN when defined.
module tb_mux_2to1_stream_arb;

    logic       clk;
    logic       rst_n;
    logic [7:0] i0;
    logic       i0_valid;
    logic       i0_ready;
    logic [7:0] i1;
    logic       i1_valid;
    logic       i1_ready;
    logic [7:0] o;
    logic       o_valid;
    logic       o_ready;
    logic       o_sel;

    int total;
    int bad;

    mux_2to1_stream_arb #(.width(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i0       (i0),
        .i0_valid (i0_valid),
        .i0_ready (i0_ready),
        .i1       (i1),
        .i1_valid (i1_valid),
        .i1_ready (i1_ready),
        .o        (o),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .o_sel    (o_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i0       = 8'h00;
        i0_valid = 1'b0;
        i1       = 8'h00;
        i1_valid = 1'b0;
        o_ready  = 1'b0;
    endtask

    task automatic pulse_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        o_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            i0       = 8'h10 + 8'(k);
            i1       = 8'h20 + 8'(k);
            i0_valid = k[0];
            i1_valid = !k[0];
            step();
            total++;
            if (o !== 8'h00 || o_valid !== 1'b0 || o_sel !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_regs cycle %0d: o=%h o_valid=%b o_sel=%b, want o=00 o_valid=0 o_sel=0",
                         k, o, o_valid, o_sel);
            end
            total++;
            if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
                bad++;
                $display("[TB] FAIL reset_ready cycle %0d: i0_ready=%b i1_ready=%b, want 0 0",
                         k, i0_ready, i1_ready);
            end
        end
        idle_inputs();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single_source();
        i1       = 8'hA5;
        i1_valid = 1'b1;
        o_ready  = 1'b1;
        #1;
        total++;
        if (i1_ready !== 1'b1 || i0_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_ready: i0_ready=%b i1_ready=%b, want 0 1", i0_ready, i1_ready);
        end
        step();
        i1_valid = 1'b0;
        total++;
        if (o !== 8'hA5 || o_sel !== 1'b1 || o_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_out: o=%h o_sel=%b o_valid=%b, want a5 1 1", o, o_sel, o_valid);
        end
        step();
        total++;
        if (o_valid !== 1'b0 || o !== 8'hA5 || o_sel !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_drain: o=%h o_sel=%b o_valid=%b, want a5 1 0", o, o_sel, o_valid);
        end
    endtask

    task automatic test_backpressure();
        i0       = 8'h3C;
        i0_valid = 1'b1;
        o_ready  = 1'b1;
        step();
        i0      = 8'h5A;
        o_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if (i0_ready !== 1'b0 || o !== 8'h3C || o_valid !== 1'b1 || o_sel !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_hold cycle %0d: i0_ready=%b o=%h o_valid=%b o_sel=%b, want 0 3c 1 0",
                         k, i0_ready, o, o_valid, o_sel);
            end
            step();
        end
        o_ready = 1'b1;
        #1;
        total++;
        if (i0_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL bp_release_ready: i0_ready=%b, want 1", i0_ready);
        end
        step();
        i0_valid = 1'b0;
        total++;
        if (o !== 8'h5A || o_valid !== 1'b1 || o_sel !== 1'b0) begin
            bad++;
            $display("[TB] FAIL bp_release_out: o=%h o_valid=%b o_sel=%b, want 5a 1 0", o, o_valid, o_sel);
        end
        step();
    endtask

    task automatic test_contention();
        logic exp_sel;
        pulse_reset();
        i0       = 8'h11;
        i1       = 8'h22;
        i0_valid = 1'b1;
        i1_valid = 1'b1;
        o_ready  = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef RR_ARB_EN
            exp_sel = k[0];
`else
            exp_sel = 1'b0;
`endif
            #1;
            total++;
            if (i0_ready !== !exp_sel || i1_ready !== exp_sel) begin
                bad++;
                $display("[TB] FAIL contend_ready %0d: i0_ready=%b i1_ready=%b, want %b %b",
                         k, i0_ready, i1_ready, !exp_sel, exp_sel);
            end
            step();
            total++;
            if (o_sel !== exp_sel || o !== (exp_sel ? 8'h22 : 8'h11) || o_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL contend_out %0d: o_sel=%b o=%h o_valid=%b, want %b %h 1",
                         k, o_sel, o, o_valid, exp_sel, exp_sel ? 8'h22 : 8'h11);
            end
        end
        idle_inputs();
        o_ready = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec_data [3];
        logic       vec_src  [3];
        vec_data = '{8'h01, 8'h02, 8'h03};
        vec_src  = '{1'b0, 1'b1, 1'b0};
        o_ready  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i0       = vec_data[k];
            i1       = vec_data[k];
            i0_valid = !vec_src[k];
            i1_valid = vec_src[k];
            step();
            total++;
            if (o !== vec_data[k] || o_sel !== vec_src[k] || o_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL b2b %0d: o=%h o_sel=%b o_valid=%b, want %h %b 1",
                         k, o, o_sel, o_valid, vec_data[k], vec_src[k]);
            end
        end
        idle_inputs();
        o_ready = 1'b1;
        step();
    endtask

    task automatic test_async_reset();
        i0       = 8'h77;
        i0_valid = 1'b1;
        o_ready  = 1'b1;
        step();
        i0_valid = 1'b0;
        o_ready  = 1'b0;
        total++;
        if (o_valid !== 1'b1 || o !== 8'h77) begin
            bad++;
            $display("[TB] FAIL async_pre: o=%h o_valid=%b, want 77 1", o, o_valid);
        end
        #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (o_valid !== 1'b0 || o !== 8'h00 || o_sel !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_reset: o=%h o_valid=%b o_sel=%b, want 00 0 0", o, o_valid, o_sel);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle_inputs();
        rst_n = 1'b0;
        $display("[TB] starting mux_2to1_stream_arb bench");
        test_reset();
        test_single_source();
        test_backpressure();
        test_contention();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
